// File: rtl/gray_codec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gray_codec_pkg
// Purpose  : Shared width limits and the binary/Gray conversion functions.
// Revision : 1.0 - initial release
// ============================================================================
package gray_codec_pkg;

   localparam int DEFAULT_DW  = 9;
   localparam int DEFAULT_SYN = 2;
   localparam int MAX_DW      = 64;

   typedef logic [MAX_DW-1:0] code_t;

   // Callers zero-extend narrower codes; leading zeros change neither mapping.
   function automatic code_t bin2gray(input code_t b);
      return b ^ (b >> 1);
   endfunction

   function automatic code_t gray2bin(input code_t g);
      code_t b;
      b[MAX_DW-1] = g[MAX_DW-1];
      for (int i = MAX_DW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/gray_codec_if.sv
`default_nettype none
// ============================================================================
// Module   : gray_codec_if
// Purpose  : Valid-qualified input/output bundle of the Gray code converter.
// Revision : 1.0 - initial release
// ============================================================================
interface gray_codec_if #(
   parameter int DW = 9
);
   logic          in_vld;
   logic [DW-1:0] bin_in;
   logic [DW-1:0] gray_in;
   logic          out_vld;
   logic [DW-1:0] gray_out;
   logic [DW-1:0] bin_out;

   modport master (
      output in_vld,
      output bin_in,
      output gray_in,
      input  out_vld,
      input  gray_out,
      input  bin_out
   );

   modport slave (
      input  in_vld,
      input  bin_in,
      input  gray_in,
      output out_vld,
      output gray_out,
      output bin_out
   );
endinterface
`default_nettype wire

// File: rtl/gray_sync.sv
`default_nettype none
// ============================================================================
// Module   : gray_sync
// Purpose  : DW-wide, SYNC_STAGES-deep flop chain with async active-low reset.
// Revision : 1.0 - initial release
// ============================================================================
module gray_sync #(
   parameter int DW          = 9,
   parameter int SYNC_STAGES = 2
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   input  wire logic [DW-1:0] d,
   output logic      [DW-1:0] q
);

   logic [DW-1:0] stage_q [SYNC_STAGES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= d;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign q = stage_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/gray_codec.sv
`default_nettype none
// ============================================================================
// Module   : gray_codec
// Purpose  : Registered binary->Gray and Gray->binary lanes for FIFO pointers.
//            Define GRAY_SYNC_EN to put a gray_sync chain ahead of the decoder.
// Revision : 1.0 - initial release
// ============================================================================
module gray_codec
   import gray_codec_pkg::*;
#(
   parameter int DW          = DEFAULT_DW,
   parameter int SYNC_STAGES = DEFAULT_SYN
) (
   input  wire logic    clk,
   input  wire logic    rst_n,
   gray_codec_if.slave  bus
);

   logic [DW-1:0] dec_src;
   logic          dec_vld;
   logic [DW-1:0] enc_next;
   logic [DW-1:0] dec_next;
   logic [DW-1:0] gray_q;
   logic [DW-1:0] bin_q;
   logic          vld_q;

`ifdef GRAY_SYNC_EN
   logic [DW:0] sync_q;

   // Valid travels in the same chain so the bin lane hold lines up with its data.
   gray_sync #(
      .DW          (DW + 1),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     ({bus.in_vld, bus.gray_in}),
      .q     (sync_q)
   );

   assign dec_vld = sync_q[DW];
   assign dec_src = sync_q[DW-1:0];
`else
   if (SYNC_STAGES >= 2) begin : g_direct_decode
   end
   assign dec_vld = bus.in_vld;
   assign dec_src = bus.gray_in;
`endif

   assign enc_next = DW'(bin2gray(code_t'(bus.bin_in)));
   assign dec_next = DW'(gray2bin(code_t'(dec_src)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gray_q <= '0;
         bin_q  <= '0;
         vld_q  <= 1'b0;
      end else begin
         vld_q <= bus.in_vld;
         if (bus.in_vld) begin
            gray_q <= enc_next;
         end
         if (dec_vld) begin
            bin_q <= dec_next;
         end
      end
   end

   assign bus.out_vld  = vld_q;
   assign bus.gray_out = gray_q;
   assign bus.bin_out  = bin_q;

endmodule
`default_nettype wire

// File: tb/tb_gray_codec.sv
`default_nettype none
// ============================================================================
// Module   : tb_gray_codec
// Purpose  : Directed vector bench for gray_codec at DW=4, DW=9 and DW=1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gray_codec;
   import gray_codec_pkg::*;

   localparam int SYNC_STAGES = 2;
`ifdef GRAY_SYNC_EN
   localparam int LAT = SYNC_STAGES + 1;
`else
   localparam int LAT = 1;
`endif

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   gray_codec_if #(.DW(4)) if4 ();
   gray_codec_if #(.DW(9)) if9 ();
   gray_codec_if #(.DW(1)) if1 ();

   gray_codec #(.DW(4), .SYNC_STAGES(SYNC_STAGES)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
   gray_codec #(.DW(9), .SYNC_STAGES(SYNC_STAGES)) u_dut9 (.clk(clk), .rst_n(rst_n), .bus(if9.slave));
   gray_codec #(.DW(1), .SYNC_STAGES(SYNC_STAGES)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [3:0] bin;
      logic [3:0] gray;
      logic [3:0] exp_gray;
      logic [3:0] exp_bin;
   } vec_t;

   vec_t vecs [7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      logic [8:0] g;
      logic [8:0] g_prev;
      logic [8:0] g0;
      tests = 0;
      fails = 0;
      g_prev = '0;
      g0 = '0;

      vecs[0] = '{4'b1011, 4'b1110, 4'b1110, 4'b1011};
      vecs[1] = '{4'b1111, 4'b1000, 4'b1000, 4'b1111};
      vecs[2] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
      vecs[3] = '{4'b0101, 4'b0110, 4'b0111, 4'b0100};
      vecs[4] = '{4'b1000, 4'b0111, 4'b1100, 4'b0101};
      vecs[5] = '{4'b0110, 4'b1100, 4'b0101, 4'b1000};
      vecs[6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};

      // Reset with all-ones inputs and valid asserted; reset must dominate.
      rst_n = 1'b0;
      if4.in_vld = 1'b1; if4.bin_in = 4'hF;   if4.gray_in = 4'hF;
      if9.in_vld = 1'b1; if9.bin_in = 9'h1FF; if9.gray_in = 9'h1FF;
      if1.in_vld = 1'b1; if1.bin_in = 1'b1;   if1.gray_in = 1'b1;
      #12;
      check("rst_gray4", 64'(if4.gray_out), 64'h0);
      check("rst_bin4",  64'(if4.bin_out),  64'h0);
      check("rst_vld4",  64'(if4.out_vld),  64'h0);
      if4.in_vld = 1'b0; if9.in_vld = 1'b0; if1.in_vld = 1'b0;
      rst_n = 1'b1;
      repeat (2) begin
         tick();
         check("idle_gray4", 64'(if4.gray_out), 64'h0);
         check("idle_bin4",  64'(if4.bin_out),  64'h0);
         check("idle_vld4",  64'(if4.out_vld),  64'h0);
      end

      // Table vectors, held LAT cycles so the bin lane also settles.
      for (int i = 0; i < 7; i++) begin
         if4.bin_in  = vecs[i].bin;
         if4.gray_in = vecs[i].gray;
         if4.in_vld  = 1'b1;
         repeat (LAT) tick();
         check($sformatf("vec%0d_gray", i), 64'(if4.gray_out), 64'(vecs[i].exp_gray));
         check($sformatf("vec%0d_bin", i),  64'(if4.bin_out),  64'(vecs[i].exp_bin));
         check($sformatf("vec%0d_vld", i),  64'(if4.out_vld),  64'h1);
      end

      // Valid low: outputs hold while inputs wander.
      if4.in_vld  = 1'b0;
      if4.bin_in  = 4'b1010;
      if4.gray_in = 4'b1010;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("hold_gray", 64'(if4.gray_out), 64'h1);
         check("hold_bin",  64'(if4.bin_out),  64'h1);
         check("hold_vld",  64'(if4.out_vld),  64'h0);
      end

      // Reset pulsed between clock edges clears outputs immediately.
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_gray", 64'(if4.gray_out), 64'h0);
      check("midrst_bin",  64'(if4.bin_out),  64'h0);
      check("midrst_vld",  64'(if4.out_vld),  64'h0);
      #1;
      rst_n = 1'b1;
      tick();

      // Single valid pulse: gray lane after 1 edge, bin lane after LAT edges.
      if4.bin_in  = 4'b0011;
      if4.gray_in = 4'b0110;
      if4.in_vld  = 1'b1;
      tick();
      if4.in_vld  = 1'b0;
      if4.bin_in  = 4'b1111;
      if4.gray_in = 4'b1111;
      check("pulse_gray_e1", 64'(if4.gray_out), 64'b0010);
      check("pulse_vld_e1",  64'(if4.out_vld),  64'h1);
      check("pulse_bin_e1",  64'(if4.bin_out),  (LAT == 1) ? 64'b0100 : 64'h0);
      for (int k = 2; k <= LAT + 1; k++) begin
         tick();
         check($sformatf("pulse_gray_e%0d", k), 64'(if4.gray_out), 64'b0010);
         check($sformatf("pulse_vld_e%0d", k),  64'(if4.out_vld),  64'h0);
         check($sformatf("pulse_bin_e%0d", k),  64'(if4.bin_out),  (k >= LAT) ? 64'b0100 : 64'h0);
      end

      // Exhaustive DW=9 sweep with gray_out looped back into gray_in.
      for (int v = 0; v < 512; v++) begin
         if9.bin_in = 9'(v);
         if9.in_vld = 1'b1;
         tick();
         g = if9.gray_out;
         check("sweep_enc", 64'(g), 64'(9'(bin2gray(code_t'(v)))));
         if (v == 0) begin
            g0 = g;
            check("sweep_zero", 64'(g), 64'h0);
         end else begin
            check("sweep_onebit", 64'($countones(g ^ g_prev)), 64'h1);
         end
         g_prev = g;
         if9.gray_in = g;
         repeat (LAT) tick();
         check("sweep_dec", 64'(if9.bin_out), 64'(v));
      end
      check("sweep_max",  64'(g_prev), 64'h100);
      check("sweep_wrap", 64'($countones(g_prev ^ g0)), 64'h1);
      if9.in_vld = 1'b0;

      // DW=1 is the identity mapping.
      for (int v = 0; v < 2; v++) begin
         if1.bin_in  = 1'(v);
         if1.gray_in = 1'(v);
         if1.in_vld  = 1'b1;
         repeat (LAT) tick();
         check("dw1_gray", 64'(if1.gray_out), 64'(v));
         check("dw1_bin",  64'(if1.bin_out),  64'(v));
      end
      if1.in_vld = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish by 200000");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
